// File: rtl/run_before_decoder_pkg.sv
// Shared CAVLC types for the run_before decoder: FSM states, field widths and coefficient type.
package run_before_decoder_pkg;

  localparam int unsigned COEFF_W = 8;
  localparam int unsigned TC_W    = 5;
  localparam int unsigned TZ_W    = 4;
  localparam int unsigned RB_W    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPlace,
    StDone
  } state_e;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/run_before_decoder.sv
// Rebuilds a zig-zag ordered coefficient block from CAVLC total_coeff/total_zeros and
// (level, run_before) pairs. Define RB_DEC_ERR_CHK_EN to enable syntax checking and rb clamping.
module run_before_decoder
  import run_before_decoder_pkg::*;
#(
  parameter int unsigned MAX_COEFF = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [TC_W-1:0]                total_coeff_i,
  input  logic [TZ_W-1:0]                total_zeros_i,
  input  logic                           level_valid_i,
  input  logic [COEFF_W-1:0]             level_i,
  input  logic [RB_W-1:0]                run_before_i,
  output logic                           level_ready_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [MAX_COEFF*COEFF_W-1:0]   coeff_o,
  output logic                           error_o
);

  state_e                              state_q;
  logic [TC_W-1:0]                     pos_q;
  logic [TZ_W-1:0]                     zl_q;
  logic [TC_W-1:0]                     idx_q;
  logic [TC_W-1:0]                     tc_q;
  logic [MAX_COEFF-1:0][COEFF_W-1:0]   coeff_q;
  logic                                done_q;
  logic                                err_q;

  logic            last;
  logic [RB_W-1:0] rb;
  logic            rb_over;
  logic [TC_W-1:0] start_pos;
  logic            start_bad;

`ifdef RB_DEC_ERR_CHK_EN
  logic [TC_W:0] start_sum;
`endif

  always_comb begin
    last      = (idx_q == tc_q - 5'd1);
    start_pos = total_coeff_i + {1'b0, total_zeros_i} - 5'd1;
`ifdef RB_DEC_ERR_CHK_EN
    start_sum = {1'b0, total_coeff_i} + {2'b00, total_zeros_i};
    start_bad = (start_sum > (TC_W+1)'(MAX_COEFF)) || (total_coeff_i > TC_W'(MAX_COEFF));
    rb_over   = (run_before_i > zl_q);
    rb        = rb_over ? zl_q : ((zl_q == '0) ? '0 : run_before_i);
`else
    start_bad = 1'b0;
    rb_over   = 1'b0;
    rb        = (zl_q == '0) ? '0 : run_before_i;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      zl_q    <= '0;
      idx_q   <= '0;
      tc_q    <= '0;
      coeff_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            coeff_q <= '0;
            err_q   <= start_bad;
            pos_q   <= start_pos;
            zl_q    <= total_zeros_i;
            idx_q   <= '0;
            tc_q    <= total_coeff_i;
            if (total_coeff_i == '0 || start_bad) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPlace;
            end
          end
        end
        StPlace: begin
          if (level_valid_i) begin
            // Positions outside the block are silently dropped.
            for (int i = 0; i < MAX_COEFF; i++) begin
              if (pos_q == TC_W'(i)) coeff_q[i] <= level_i;
            end
            if (last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              pos_q <= pos_q - 5'd1 - {1'b0, rb};
              zl_q  <= zl_q - rb;
              idx_q <= idx_q + 5'd1;
              if (rb_over) err_q <= 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign level_ready_o = (state_q == StPlace);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign coeff_o       = coeff_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_run_before_decoder.sv
// Directed self-checking bench for run_before_decoder (default 16-entry block).
module tb_run_before_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [4:0]   total_coeff_i;
  logic [3:0]   total_zeros_i;
  logic         level_valid_i;
  logic [7:0]   level_i;
  logic [3:0]   run_before_i;
  logic         level_ready_o;
  logic         busy_o;
  logic         done_o;
  logic [127:0] coeff_o;
  logic         error_o;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_blk;

  run_before_decoder #(.MAX_COEFF(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .total_coeff_i (total_coeff_i),
    .total_zeros_i (total_zeros_i),
    .level_valid_i (level_valid_i),
    .level_i       (level_i),
    .run_before_i  (run_before_i),
    .level_ready_o (level_ready_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .coeff_o       (coeff_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] tc, input logic [3:0] tz);
    start_i       = 1'b1;
    total_coeff_i = tc;
    total_zeros_i = tz;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic pair(input logic [7:0] lvl, input logic [3:0] rb);
    level_valid_i = 1'b1;
    level_i       = lvl;
    run_before_i  = rb;
    tick();
    level_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; total_coeff_i = '0; total_zeros_i = '0;
    level_valid_i = 1'b0; level_i = '0; run_before_i = '0;
    tick(); tick();
    check("rst_busy", busy_o, 0);
    check("rst_ready", level_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_coeff", coeff_o, 0);
    rst = 1'b1;
    tick();

    // Example block: TC=5, TZ=4.
    do_start(5, 4);
    check("ex_busy", busy_o, 1);
    check("ex_ready", level_ready_o, 1);
    pair(8'd1, 4'd1);
    pair(8'd1, 4'd0);
    pair(8'hFF, 4'd2);
    check("ex_nodone_mid", done_o, 0);
    pair(8'hFF, 4'd0);
    pair(8'd3, 4'd5);
    exp_blk = '0;
    exp_blk[1*8 +: 8] = 8'd3;
    exp_blk[2*8 +: 8] = 8'hFF;
    exp_blk[5*8 +: 8] = 8'hFF;
    exp_blk[6*8 +: 8] = 8'd1;
    exp_blk[8*8 +: 8] = 8'd1;
    check("ex_done", done_o, 1);
    check("ex_coeff", coeff_o, exp_blk);
    check("ex_error", error_o, 0);
    check("ex_ready_done", level_ready_o, 0);
    tick();
    check("ex_done_pulse", done_o, 0);
    check("ex_idle", busy_o, 0);

    // level_valid_i in IDLE must not alter the block.
    level_valid_i = 1'b1; level_i = 8'h77;
    tick();
    level_valid_i = 1'b0;
    check("idle_valid_ignored", coeff_o, exp_blk);

    // TC=0: done the cycle after start, block cleared.
    do_start(0, 0);
    check("tc0_done", done_o, 1);
    check("tc0_ready", level_ready_o, 0);
    check("tc0_coeff", coeff_o, 0);
    tick();
    check("tc0_done_pulse", done_o, 0);
    check("tc0_ready2", level_ready_o, 0);
    check("tc0_idle", busy_o, 0);

    // TC=16 with valid toggling.
    do_start(16, 0);
    for (int k = 0; k < 16; k++) begin
      level_valid_i = 1'b1;
      level_i       = 8'(16 - k);
      run_before_i  = 4'd0;
      tick();
      if (k < 15) begin
        level_valid_i = 1'b0;
        level_i       = 8'hAA;
        tick();
      end
      if (k == 7) check("tc16_ready_mid", level_ready_o, 1);
    end
    level_valid_i = 1'b0;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) exp_blk[i*8 +: 8] = 8'(i + 1);
    check("tc16_done", done_o, 1);
    check("tc16_coeff", coeff_o, exp_blk);
    tick();

    // TC=2, TZ=3: zeros_left exhausted; start during DONE is ignored.
    do_start(2, 3);
    pair(8'd5, 4'd3);
    pair(8'd7, 4'd9);
    exp_blk = '0;
    exp_blk[4*8 +: 8] = 8'd5;
    exp_blk[0*8 +: 8] = 8'd7;
    check("tz3_done", done_o, 1);
    check("tz3_coeff", coeff_o, exp_blk);
    start_i = 1'b1; total_coeff_i = 5'd1; total_zeros_i = 4'd0;
    tick();
    start_i = 1'b0;
    check("done_start_ignored", busy_o, 0);
    tick();
    check("done_start_ignored2", busy_o, 0);
    check("done_start_coeff", coeff_o, exp_blk);

    // TC=2, TZ=1 with oversized run_before.
    do_start(2, 1);
    pair(8'd4, 4'd3);
    pair(8'd2, 4'd0);
    check("clamp_done", done_o, 1);
`ifdef RB_DEC_ERR_CHK_EN
    exp_blk = '0;
    exp_blk[2*8 +: 8] = 8'd4;
    exp_blk[0*8 +: 8] = 8'd2;
    check("clamp_coeff", coeff_o, exp_blk);
    check("clamp_error", error_o, 1);
    tick();
    do_start(10, 8);
    check("ovf_done", done_o, 1);
    check("ovf_error", error_o, 1);
    check("ovf_coeff", coeff_o, 0);
`else
    check("clamp_error_off", error_o, 0);
`endif
    tick();

    // Reset mid-block, then a clean block.
    do_start(5, 4);
    pair(8'd1, 4'd1);
    pair(8'd1, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", level_ready_o, 0);
    check("mid_rst_coeff", coeff_o, 0);
    check("mid_rst_error", error_o, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_no_done", done_o, 0);
    do_start(3, 0);
    pair(8'd9, 4'd0);
    pair(8'd8, 4'd0);
    pair(8'd7, 4'd0);
    exp_blk = '0;
    exp_blk[2*8 +: 8] = 8'd9;
    exp_blk[1*8 +: 8] = 8'd8;
    exp_blk[0*8 +: 8] = 8'd7;
    check("post_rst_done", done_o, 1);
    check("post_rst_coeff", coeff_o, exp_blk);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
